// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one single-port unified instruction/data memory between the fetch
// stage and the memory stage. Only one transaction is in flight at a time,
// and each one takes a fixed MEM_LAT cycles. Data requests win ties against
// fetch because the data access belongs to the older instruction.
//
// Optional feature (macro ARB_STARVE_GUARD_EN):
//   When defined, a saturating counter tracks data grants issued while a
//   fetch is waiting. Once it reaches STARVE_MAX and both requests are
//   pending, fetch is granted ahead of data. When the macro is not defined,
//   data has fixed priority and STARVE_MAX has no effect.
//
// Ports:
//   clk_i, reset_i        clock; synchronous active-low reset
//   if_req_i, if_addr_i   fetch request, held until if_rvalid_o
//   if_gnt_o              one-cycle pulse when the fetch is issued
//   if_rvalid_o           one-cycle pulse; if_rdata_o is valid
//   if_rdata_o            registered fetched word
//   d_req_i, d_we_i       data request and store flag, held until d_rvalid_o
//   d_addr_i, d_wdata_i   data address and store data
//   d_gnt_o               one-cycle pulse when the data access is issued
//   d_rvalid_o            one-cycle pulse; load data valid or store done
//   d_rdata_o             registered load word; 0 for stores
//   mem_en_o, mem_we_o    memory strobe and write enable (grant cycle only)
//   mem_addr_o            memory address; 0 when mem_en_o is low
//   mem_wdata_o           memory write data; 0 when mem_en_o is low
//   mem_rdata_i           memory read data, valid MEM_LAT cycles after issue
//   stall_f_o, stall_m_o  stall requests to the hazard unit
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no access in flight; combinational arbitration, grant may fire
// BUSY_I | fetch in flight; lat_q counts up to MEM_LAT
// BUSY_D | data access in flight; lat_q counts up to MEM_LAT

module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_f_o,
    output logic              stall_m_o
);

    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
        $error("mem_port_arbiter: MEM_LAT must be in 1..15");
    end

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("mem_port_arbiter: STARVE_MAX must be in 1..15");
    end

    localparam logic [3:0] LAT_LAST = 4'(MEM_LAT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          lat_q, lat_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                if_rvalid_q, if_rvalid_d;
    logic                d_rvalid_q, d_rvalid_d;
    logic                fetch_first;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_q, starve_d;

    // Fetch jumps the queue only when it has been passed over STARVE_MAX
    // times and is actually competing with data this cycle.
    assign fetch_first = if_req_i & d_req_i & (starve_q == STARVE_LIM);

    always_comb begin
        starve_d = starve_q;
        if (if_gnt_o) begin
            starve_d = '0;
        end else if (d_gnt_o && if_req_i && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign fetch_first = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        we_d        = we_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_gnt_o    = 1'b0;
        d_gnt_o     = 1'b0;
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;

        unique case (state_q)
            IDLE: begin
                lat_d = 4'd0;
                // Grants are suppressed while reset is asserted so nothing
                // reaches memory during a reset cycle.
                if (reset_i) begin
                    if (d_req_i && !fetch_first) begin
                        d_gnt_o     = 1'b1;
                        mem_en_o    = 1'b1;
                        mem_we_o    = d_we_i;
                        mem_addr_o  = d_addr_i;
                        mem_wdata_o = d_wdata_i;
                        we_d        = d_we_i;
                        lat_d       = 4'd1;
                        state_d     = BUSY_D;
                    end else if (if_req_i) begin
                        if_gnt_o    = 1'b1;
                        mem_en_o    = 1'b1;
                        mem_addr_o  = if_addr_i;
                        lat_d       = 4'd1;
                        state_d     = BUSY_I;
                    end
                end
            end
            BUSY_I: begin
                if (lat_q == LAT_LAST) begin
                    if_rdata_d  = mem_rdata_i;
                    if_rvalid_d = 1'b1;
                    lat_d       = 4'd0;
                    state_d     = IDLE;
                end else begin
                    lat_d = lat_q + 4'd1;
                end
            end
            BUSY_D: begin
                if (lat_q == LAT_LAST) begin
                    // A store returns no data; report zero rather than
                    // whatever the memory happens to drive.
                    d_rdata_d  = we_q ? '0 : mem_rdata_i;
                    d_rvalid_d = 1'b1;
                    lat_d      = 4'd0;
                    state_d    = IDLE;
                end else begin
                    lat_d = lat_q + 4'd1;
                end
            end
            default: begin
                lat_d   = 4'd0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q     <= IDLE;
            lat_q       <= 4'd0;
            we_q        <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            we_q        <= we_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
        end
    end

    assign if_rvalid_o = if_rvalid_q;
    assign d_rvalid_o  = d_rvalid_q;
    assign if_rdata_o  = if_rdata_q;
    assign d_rdata_o   = d_rdata_q;

    // Stalls drop in the rvalid cycle so the pipeline advances on that edge.
    assign stall_f_o = if_req_i & ~if_rvalid_q;
    assign stall_m_o = d_req_i & ~d_rvalid_q;

endmodule
